// File: rtl/pipereg_elastic.sv
// Chain of elastic pipeline stages with valid/ready handshaking, a 2-entry skid
// buffer per stage, synchronous flush and a registered occupancy count.
module pipereg_elastic #(
  parameter int DATA_W     = 32,
  parameter int CTRL_W     = 8,
  parameter int NUM_STAGES = 1,
  parameter int CLEAR_DATA = 0,
  parameter int CNT_W      = $clog2(2*NUM_STAGES+1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  occupancy
);

  // Index k is the input of stage k; index NUM_STAGES is the block output.
  logic              w_up_valid [NUM_STAGES+1];
  logic [DATA_W-1:0] w_up_data  [NUM_STAGES+1];
  logic [CTRL_W-1:0] w_up_ctrl  [NUM_STAGES+1];
  logic              w_skid_vld [NUM_STAGES];
  logic              w_dn_ready [NUM_STAGES];

  assign w_up_valid[0] = in_valid;
  assign w_up_data[0]  = in_data;
  assign w_up_ctrl[0]  = in_ctrl;

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    logic              r_main_vld, r_skid_vld;
    logic [DATA_W-1:0] r_main_data, r_skid_data;
    logic [CTRL_W-1:0] r_main_ctrl, r_skid_ctrl;
    logic              w_acc, w_dn;

    assign w_acc = w_up_valid[k] && !r_skid_vld;
    assign w_dn  = r_main_vld && w_dn_ready[k];

    if (k == NUM_STAGES-1) begin : g_last
      assign w_dn_ready[k] = out_ready;
    end else begin : g_mid
      assign w_dn_ready[k] = !w_skid_vld[k+1];
    end

    // NOTE: all state below uses non-blocking assignments so every stage samples
    // its neighbours' pre-edge values and the chain shifts exactly one hop per edge.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_main_vld  <= 1'b0;
        r_skid_vld  <= 1'b0;
        r_main_data <= '0;
        r_skid_data <= '0;
        r_main_ctrl <= '0;
        r_skid_ctrl <= '0;
      end else if (flush) begin
        r_main_vld  <= 1'b0;
        r_skid_vld  <= 1'b0;
        r_main_ctrl <= '0;
        r_skid_ctrl <= '0;
        if (CLEAR_DATA != 0) begin
          r_main_data <= '0;
          r_skid_data <= '0;
        end
      end else if (r_skid_vld) begin
        // TWO: upstream is stalled, only draining can happen.
        if (w_dn) begin
          r_main_data <= r_skid_data;
          r_main_ctrl <= r_skid_ctrl;
          r_skid_vld  <= 1'b0;
        end
      end else if (w_acc) begin
        if (!r_main_vld || w_dn) begin
          r_main_vld  <= 1'b1;
          r_main_data <= w_up_data[k];
          r_main_ctrl <= w_up_ctrl[k];
        end else begin
          r_skid_vld  <= 1'b1;
          r_skid_data <= w_up_data[k];
          r_skid_ctrl <= w_up_ctrl[k];
        end
      end else if (w_dn) begin
        r_main_vld <= 1'b0;
      end
    end

    assign w_skid_vld[k]   = r_skid_vld;
    assign w_up_valid[k+1] = r_main_vld;
    assign w_up_data[k+1]  = r_main_data;
    assign w_up_ctrl[k+1]  = r_main_ctrl;
  end

  // Ready comes straight from a flop, so out_ready never reaches in_ready combinationally.
  assign in_ready  = !w_skid_vld[0];
  assign out_valid = w_up_valid[NUM_STAGES];
  assign out_data  = w_up_data[NUM_STAGES];
  assign out_ctrl  = w_up_ctrl[NUM_STAGES] & {CTRL_W{out_valid}};

  logic w_in_xfer, w_out_xfer;
  logic [CNT_W-1:0] r_occ;

  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_occ <= '0;
    end else if (w_in_xfer && !w_out_xfer) begin
      r_occ <= r_occ + CNT_W'(1);
    end else if (!w_in_xfer && w_out_xfer) begin
      r_occ <= r_occ - CNT_W'(1);
    end
  end

  assign occupancy = r_occ;

endmodule

// File: tb/tb_pipereg_elastic.sv
// Self-checking bench: four pipereg_elastic variants share one stimulus stream,
// each tracked by its own scoreboard queue, plus directed latency/flush/reset checks.
module tb_pipereg_elastic;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_data;
  logic [7:0]  in_ctrl;

  logic        in_ready_w  [4];
  logic        out_valid_w [4];
  logic [31:0] out_data_w  [4];
  logic [7:0]  out_ctrl_w  [4];
  logic [3:0]  occ_w       [4];

  logic [39:0] sb [4][$];
  logic [39:0] mon_exp;
  logic        mon_en = 1'b0;
  int          vectors = 0;
  int          errors  = 0;

  always #5 clk = ~clk;

  // g0: 1 stage, data held on flush; g1: 1 stage, data cleared; g2: 2 stages; g3: 3 stages.
  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int NS = (g < 2) ? 1 : g;
    localparam int CW = $clog2(2*NS+1);
    logic [CW-1:0] occ;
    pipereg_elastic #(
      .DATA_W(32), .CTRL_W(8), .NUM_STAGES(NS), .CLEAR_DATA((g == 1) ? 1 : 0)
    ) u_dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready_w[g]),
      .in_data(in_data), .in_ctrl(in_ctrl),
      .out_valid(out_valid_w[g]), .out_ready(out_ready),
      .out_data(out_data_w[g]), .out_ctrl(out_ctrl_w[g]),
      .occupancy(occ)
    );
    assign occ_w[g] = 4'(occ);
  end

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic check_idle(input int g, input string tag, input logic [31:0] data_exp);
    check({tag, "_valid"}, 40'(out_valid_w[g]), 40'(0));
    check({tag, "_ctrl"},  40'(out_ctrl_w[g]),  40'(0));
    check({tag, "_data"},  40'(out_data_w[g]),  40'(data_exp));
    check({tag, "_occ"},   40'(occ_w[g]),       40'(0));
    check({tag, "_ready"}, 40'(in_ready_w[g]),  40'(1));
  endtask

  // Scoreboard monitor: sampled mid-cycle while inputs are stable.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int g = 0; g < 4; g++) begin
        check("occ_vs_sb", 40'(occ_w[g]), 40'(sb[g].size()));
        if (g < 2) check("in_ready_vs_sb", 40'(in_ready_w[g]), 40'(sb[g].size() < 2));
        if (!out_valid_w[g]) check("bubble_ctrl", 40'(out_ctrl_w[g]), 40'(0));
        if (out_valid_w[g] && out_ready) begin
          if (sb[g].size() == 0) begin
            check("spurious_out", {out_ctrl_w[g], out_data_w[g]}, 40'hXX_DEAD_BEEF);
          end else begin
            mon_exp = sb[g].pop_front();
            check("sb_head", {out_ctrl_w[g], out_data_w[g]}, mon_exp);
          end
        end
        if (rst || flush) sb[g].delete();
        else if (in_valid && in_ready_w[g]) sb[g].push_back({in_ctrl, in_data});
      end
    end
  end

  initial begin
    int items;
    int cycles;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_ctrl = '0;
    step();
    mon_en = 1'b1;
    step();
    rst = 1'b0;
    neg();
    for (int g = 0; g < 4; g++) check_idle(g, "reset", 32'h0);

    // Back-to-back stream through one stage, one cycle latency.
    out_ready = 1'b1; in_valid = 1'b1; in_ctrl = 8'h01; in_data = 32'h11;
    step(); in_data = 32'h22;
    neg();
    check("t1_data0", 40'(out_data_w[0]), 40'h11);
    check("t1_ctrl0", 40'(out_ctrl_w[0]), 40'h01);
    check("t1_occ0",  40'(occ_w[0]), 40'd1);
    step(); in_data = 32'h33;
    neg();
    check("t1_data1", 40'(out_data_w[0]), 40'h22);
    check("t1_ready", 40'(in_ready_w[0]), 40'd1);
    step(); in_valid = 1'b0;
    neg();
    check("t1_data2", 40'(out_data_w[0]), 40'h33);
    check("t1_occ2",  40'(occ_w[0]), 40'd1);
    repeat (8) step();

    // Two stages with backpressure: four fit, fifth is held off.
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 8'h02;
    for (int i = 0; i < 4; i++) begin
      in_data = 32'hA0 + 32'(i);
      step();
    end
    in_data = 32'hA4;
    neg();
    check("t2_ready", 40'(in_ready_w[2]), 40'd0);
    check("t2_occ",   40'(occ_w[2]), 40'd4);
    repeat (3) step();
    neg();
    check("t2_hold_occ", 40'(occ_w[2]), 40'd4);
    out_ready = 1'b1;
    begin
      bit taken = 1'b0;
      for (int i = 0; i < 10 && !taken; i++) begin
        neg();
        taken = in_ready_w[2];
        step();
      end
      check("t2_a4_taken", 40'(taken), 40'd1);
    end
    in_valid = 1'b0;
    repeat (10) step();
    neg();
    check("t2_drained", 40'(occ_w[2]), 40'd0);

    // Flush of a full single stage with a competing input.
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 8'h03;
    in_data = 32'hB1; step();
    in_data = 32'hB2; step();
    neg();
    check("t3_full", 40'(occ_w[0]), 40'd2);
    in_data = 32'h55; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    neg();
    check_idle(0, "t3_hold", 32'hB1);
    check_idle(1, "t3_clear", 32'h0);
    out_ready = 1'b1;
    repeat (6) step();

    // Reset together with flush while full; then latency of a fresh item.
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 8'h04;
    for (int i = 0; i < 8; i++) begin
      in_data = 32'hC0 + 32'(i);
      step();
    end
    rst = 1'b1; flush = 1'b1;
    step();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    neg();
    for (int g = 0; g < 4; g++) check_idle(g, "t4_reset", 32'h0);
    out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h77; in_ctrl = 8'h5A;
    step(); in_valid = 1'b0;
    neg();
    check("t4_lat1", {out_ctrl_w[0], out_data_w[0]}, {8'h5A, 32'h77});
    check("t4_lat3_early", 40'(out_valid_w[3]), 40'd0);
    step();
    neg();
    check("t4_lat2", {out_ctrl_w[2], out_data_w[2]}, {8'h5A, 32'h77});
    check("t4_lat3_early2", 40'(out_valid_w[3]), 40'd0);
    step();
    neg();
    check("t4_lat3", {out_valid_w[3], out_ctrl_w[3], out_data_w[3]}, {1'b1, 8'h5A, 32'h77});
    repeat (6) step();

    // Alternating out_ready with continuous input on a single stage.
    in_valid = 1'b1; in_ctrl = 8'h06;
    for (int i = 0; i < 20; i++) begin
      in_data   = 32'hD00 + 32'(i);
      out_ready = i[0];
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (8) step();

    // Random traffic, 50% valid and 50% ready.
    items = 0; cycles = 0;
    while (items < 10000 && cycles < 60000) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_data   = $urandom;
      in_ctrl   = 8'($urandom);
      neg();
      if (in_valid && in_ready_w[3]) items++;
      step();
      cycles++;
    end
    check("t5_items", 40'(items >= 10000), 40'd1);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (20) step();
    neg();
    for (int g = 0; g < 4; g++) check("t5_drained", 40'(occ_w[g]), 40'd0);

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
